// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment constants (active-low gfedcba) and anode encodings for the display blocks.
package seg7_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 8-digit display: refresh prescaler,
// slot counter, anti-ghost gap, leading-zero blanking and registered outputs.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned REFRESH_DIV  = 262144,
  parameter int unsigned BLANK_CYCLES = 1024,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   Dp_En,
  output logic [7:0]              Anode,
  output logic [7:0]              Display,
  output logic [2:0]              Slot
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    SLOT_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0]         count_q, count_d;
  logic [2:0]            slot_q, slot_d;
  logic [7:0]            anode_q, anode_d;
  logic [7:0]            display_q, display_d;
  logic                  tick;
  logic                  in_gap;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            digit_sel;
  logic                  dp_sel;
  logic                  lz_sel;
  logic [6:0]            seg;

  assign tick   = (count_q == CNT_LAST);
  assign in_gap = (32'(count_q) < BLANK_CYCLES);

  // Digit i (i>0) is a leading zero when it and every more-significant digit are 0;
  // the ones digit is never blanked.
  always_comb begin
    lz_mask = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lz_mask[i] = BLANK_LZ;
      for (int unsigned j = i; j < NUM_DIGITS; j++) begin
        if (Digits[4*j +: 4] != 4'd0) lz_mask[i] = 1'b0;
      end
    end
  end

  always_comb begin
    digit_sel = '0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == 3'(i)) begin
        digit_sel = Digits[4*i +: 4];
        dp_sel    = Dp_En[i];
        lz_sel    = lz_mask[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (digit_sel),
    .blank_i (lz_sel),
    .seg_o   (seg)
  );

  always_comb begin
    count_d   = tick ? '0 : count_q + 1'b1;
    slot_d    = slot_q;
    if (tick) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    anode_d   = ANODE_OFF;
    display_d = '1;
    if (Enable && !in_gap) begin
      anode_d[slot_q] = 1'b0;
      display_d       = {~dp_sel, seg};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= '0;
      slot_q    <= '0;
      anode_q   <= ANODE_OFF;
      display_q <= '1;
    end else begin
      count_q   <= count_d;
      slot_q    <= slot_d;
      anode_q   <= anode_d;
      display_q <= display_d;
    end
  end

  assign Anode   = anode_q;
  assign Display = display_q;
  assign Slot    = slot_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 3;
  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [11:0] Digits = '0;
  logic [2:0]  Dp_En = '0;
  logic [7:0]  Anode;
  logic [7:0]  Display;
  logic [2:0]  Slot;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned k = 0;
  logic        en_e;
  logic [11:0] dig_e;
  logic [2:0]  dp_e;
  logic [15:0] exp_out;

  always #5 Clk = ~Clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLANK_LZ     (1'b1)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .Digits  (Digits),
    .Dp_En   (Dp_En),
    .Anode   (Anode),
    .Display (Display),
    .Slot    (Slot)
  );

  function automatic logic [6:0] ref_seg(int unsigned v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 9) return 7'h3F;
    return tbl[v];
  endfunction

  // k = clock edges since the last reset edge; outputs after edge k reflect scan position k-1.
  function automatic logic [15:0] ref_out(int unsigned kk, logic en, logic [11:0] dig,
                                          logic [2:0] dp);
    int unsigned c, s, d;
    logic [7:0]  an;
    logic [6:0]  sg;
    if (kk == 0) return 16'hFFFF;
    c = (kk - 1) % RD;
    s = ((kk - 1) / RD) % ND;
    if (!en || c < BC) return 16'hFFFF;
    an = ~(8'd1 << s);
    d  = int'((dig >> (4 * s)) & 12'hF);
    sg = (s > 0 && (dig >> (4 * s)) == 12'h0) ? 7'h7F : ref_seg(d);
    return {an, ~dp[s], sg};
  endfunction

  function automatic logic [2:0] ref_slot(int unsigned kk);
    return 3'((kk / RD) % ND);
  endfunction

  task automatic tick();
    logic rst;
    en_e  = Enable;
    dig_e = Digits;
    dp_e  = Dp_En;
    rst   = Reset;
    @(posedge Clk);
    #1;
    k = rst ? 0 : k + 1;
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    Enable = 1'b1;
    Digits = 12'h123;
    Dp_En  = 3'b000;
    repeat (3) begin
      tick();
      n_cmp++;
      if ({Slot, Anode, Display} !== {3'd0, 8'hFF, 8'hFF}) begin
        n_err++;
        $display("FAIL reset_state: slot/anode/display got %0d/%h/%h want 0/ff/ff",
                 Slot, Anode, Display);
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({Anode, Display} !== 16'hFFFF) begin
        n_err++;
        $display("FAIL reset_gap%0d: anode/display got %h/%h want ff/ff", i, Anode, Display);
      end
    end
    tick();
    n_cmp++;
    if ({Anode, Display} !== {8'hFE, 8'hB0}) begin
      n_err++;
      $display("FAIL reset_first_drive: anode/display got %h/%h want fe/b0", Anode, Display);
    end
  endtask

  task automatic test_scan();
    Enable = 1'b1;
    Digits = 12'h123;
    Dp_En  = 3'b000;
    repeat (48) begin
      tick();
      exp_out = ref_out(k, en_e, dig_e, dp_e);
      n_cmp++;
      if ({Anode, Display} !== exp_out || Slot !== ref_slot(k) || Anode[7:3] !== 5'h1F) begin
        n_err++;
        $display("FAIL scan k=%0d: slot/anode/display got %0d/%h/%h want %0d/%h/%h",
                 k, Slot, Anode, Display, ref_slot(k), exp_out[15:8], exp_out[7:0]);
      end
    end
  endtask

  task automatic test_leading_zero();
    Enable = 1'b1;
    Dp_En  = 3'b000;
    for (int p = 0; p < 2; p++) begin
      Digits = (p == 0) ? 12'h007 : 12'h000;
      repeat (24) begin
        tick();
        exp_out = ref_out(k, en_e, dig_e, dp_e);
        n_cmp++;
        if ({Anode, Display} !== exp_out) begin
          n_err++;
          $display("FAIL lz digits=%h k=%0d: anode/display got %h/%h want %h/%h",
                   dig_e, k, Anode, Display, exp_out[15:8], exp_out[7:0]);
        end
      end
    end
  endtask

  task automatic test_dash_dp();
    Enable = 1'b1;
    Digits = 12'h0A5;
    Dp_En  = 3'b010;
    repeat (24) begin
      tick();
      exp_out = ref_out(k, en_e, dig_e, dp_e);
      n_cmp++;
      if ({Anode, Display} !== exp_out) begin
        n_err++;
        $display("FAIL dash_dp k=%0d: anode/display got %h/%h want %h/%h",
                 k, Anode, Display, exp_out[15:8], exp_out[7:0]);
      end
    end
  endtask

  task automatic test_enable();
    Digits = 12'h456;
    Dp_En  = 3'b001;
    for (int ph = 0; ph < 3; ph++) begin
      Enable = (ph != 1);
      repeat ((ph == 1) ? 20 : 11) begin
        tick();
        exp_out = ref_out(k, en_e, dig_e, dp_e);
        n_cmp++;
        if ({Anode, Display} !== exp_out || Slot !== ref_slot(k)) begin
          n_err++;
          $display("FAIL enable en=%0b k=%0d: slot/anode/display got %0d/%h/%h want %0d/%h/%h",
                   en_e, k, Slot, Anode, Display, ref_slot(k), exp_out[15:8], exp_out[7:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] d;
    repeat (300) begin
      for (int i = 0; i < 3; i++) begin
        d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      Digits = d;
      Dp_En  = 3'($urandom_range(0, 7));
      Enable = ($urandom_range(0, 7) != 0);
      tick();
      exp_out = ref_out(k, en_e, dig_e, dp_e);
      n_cmp++;
      if ({Anode, Display} !== exp_out || Slot !== ref_slot(k)) begin
        n_err++;
        $display("FAIL random k=%0d dig=%h dp=%b en=%0b: slot/anode/display got %0d/%h/%h want %0d/%h/%h",
                 k, dig_e, dp_e, en_e, Slot, Anode, Display, ref_slot(k),
                 exp_out[15:8], exp_out[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    Enable = 1'b1;
    Digits = 12'h789;
    Dp_En  = 3'b000;
    budget = 0;
    while (!((k % RD) == 5 && ((k / RD) % ND) == 2) && budget < 100) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (budget >= 100 || Slot !== 3'd2) begin
      n_err++;
      $display("FAIL reset_mid_setup: slot got %0d want 2 (cycles %0d)", Slot, budget);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({Slot, Anode, Display} !== {3'd0, 8'hFF, 8'hFF}) begin
      n_err++;
      $display("FAIL reset_mid: slot/anode/display got %0d/%h/%h want 0/ff/ff",
               Slot, Anode, Display);
    end
    repeat (3) begin
      tick();
      exp_out = ref_out(k, en_e, dig_e, dp_e);
      n_cmp++;
      if ({Anode, Display} !== exp_out || Slot !== 3'd0) begin
        n_err++;
        $display("FAIL reset_mid_restart k=%0d: slot/anode/display got %0d/%h/%h want 0/%h/%h",
                 k, Slot, Anode, Display, exp_out[15:8], exp_out[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_dash_dp();
    test_enable();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
